rs232_rx_fifo: RTL and testbench

- Receive-side buffer that sits directly downstream of the RS-232 byte receiver.
- The receiver raises ctrl high for one baud-clock period when a byte is valid on its data[7:0] output.
- This block synchronises ctrl into the system clock, detects its rising edge, captures the byte and pushes it into a DEPTH-entry FIFO.
- Software/logic drains the FIFO through a registered read port; a sticky overflow flag records dropped bytes.

---
 rtl/rs232_rx_fifo.sv | 135 +++++++++++++
 tb/tb_rs232_rx_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx_fifo.sv
// Purpose : receive-side byte buffer behind the RS-232 receiver; syncs the byte strobe, pushes bytes into a DEPTH-entry FIFO.
// Latency : a push lands 3 clk after rx_ctrl rises; a pop returns rd_data/rd_valid 1 clk after rd_en is accepted.
// Backpr. : none toward the receiver; a byte arriving while full (and no pop that cycle) is dropped and flags overflow.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   rx_ctrl, rx_byte    - receiver byte-valid strobe (async to clk) and its data
//   rd_en               - pop request; ignored while empty
//   rd_data, rd_valid   - registered popped byte and its one-cycle qualifier
//   empty, full, count  - occupancy status, derived from the registered count
//   overflow, ovf_clr   - sticky dropped-byte flag and its clear (a drop in the same cycle wins)

module rs232_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_ctrl,
    input  logic [7:0]    rx_byte,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Strobe synchroniser. All three flops reset to 1 so that a strobe
    // already high when reset releases looks like "old news" and never
    // produces an edge; only a fresh low->high transition pushes.
    // ------------------------------------------------------------------
    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= rx_ctrl;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // One-cycle pulse per strobe high period, however long it stays high.
    logic w_edge;
    assign w_edge = r_s2 & ~r_s3;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);

    assign w_pop = rd_en & ~w_empty;

    // When full, a pop in the same cycle frees the slot being written:
    // at full wptr == rptr, and the read of mem[rptr] below samples the
    // old contents before the write lands, so both can share the entry.
    assign w_push_ok = w_edge & (~w_full | w_pop);
    assign w_drop    = w_edge & ~w_push_ok;

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end

            if (w_pop) begin
                r_rd_data <= r_mem[r_rptr];
                r_rptr    <= r_rptr + AW'(1);
            end
            r_rd_valid <= w_pop;

            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase

            // A drop outranks a clear in the same cycle so no loss goes unreported.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Purpose : self-checking bench for rs232_rx_fifo (directed table, corner sequences, random push/pop).
// Latency : n/a (testbench).
// Backpr. : n/a (testbench).
`timescale 1ns/1ps

module tb_rs232_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_ctrl;
    logic [7:0]    rx_byte;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          ovf_clr;

    rs232_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_ctrl  (rx_ctrl),
        .rx_byte  (rx_byte),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: transaction-level FIFO of bytes.
    logic [7:0] mq[$];
    bit         m_ovf;
    logic [7:0] m_last;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_last = 8'h00;
    endtask

    // One receiver strobe held for 'hold' cycles, then a quiet gap long
    // enough for the synchroniser to settle.
    task automatic do_push(input logic [7:0] b, input int hold);
        rx_byte = b;
        rx_ctrl = 1'b1;
        repeat (hold) tick();
        rx_ctrl = 1'b0;
        repeat (4) tick();
        if (mq.size() < DEPTH) mq.push_back(b);
        else                   m_ovf = 1'b1;
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (mq.size() > 0) m_last = mq.pop_front();
    endtask

    task automatic pop_chk(input string name);
        bit         exp_vld;
        logic [7:0] exp_dat;
        exp_vld = (mq.size() > 0);
        exp_dat = exp_vld ? mq[0] : m_last;
        do_pop();
        chk({name, "_vld"}, rd_valid, exp_vld);
        chk({name, "_dat"}, rd_data, exp_dat);
    endtask

    task automatic state_chk(input string name);
        chk({name, "_cnt"},   count,    mq.size());
        chk({name, "_empty"}, empty,    mq.size() == 0);
        chk({name, "_full"},  full,     mq.size() == DEPTH);
        chk({name, "_ovf"},   overflow, m_ovf);
    endtask

    typedef enum int {OP_PUSH, OP_POP, OP_CLR} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] dat;
        int         exp_cnt;
        bit         exp_ovf;
        bit         exp_vld;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n;

        rst     = 1'b1;
        rx_ctrl = 1'b0;
        rx_byte = 8'h00;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
        repeat (3) tick();

        // Reset state
        chk("rst_cnt",   count,    0);
        chk("rst_empty", empty,    1);
        chk("rst_full",  full,     0);
        chk("rst_ovf",   overflow, 0);
        chk("rst_vld",   rd_valid, 0);
        chk("rst_rd",    rd_data,  8'h00);
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_cnt", count, 0);

        // Single byte with a long strobe: exactly one push
        do_push(8'hA5, 8);
        chk("single_cnt",   count, 1);
        chk("single_empty", empty, 0);
        do_pop();
        chk("single_vld", rd_valid, 1);
        chk("single_rd",  rd_data,  8'hA5);
        chk("single_cnt0",   count, 0);
        chk("single_empty1", empty, 1);
        tick();
        chk("single_vld_pulse", rd_valid, 0);

        // Fill / overflow / drain / pop-on-empty / clear, as a vector table
        for (int i = 0; i < 17; i++) begin
            v.op = OP_PUSH; v.dat = 8'(i);
            v.exp_cnt = (i < 16) ? i + 1 : 16;
            v.exp_ovf = (i == 16);
            v.exp_vld = 1'b0; v.exp_rd = 8'hA5;
            tbl.push_back(v);
        end
        for (int k = 0; k < 16; k++) begin
            v.op = OP_POP; v.dat = 8'h00;
            v.exp_cnt = 15 - k; v.exp_ovf = 1'b1;
            v.exp_vld = 1'b1;   v.exp_rd  = 8'(k);
            tbl.push_back(v);
        end
        v.op = OP_POP; v.dat = 8'h00; v.exp_cnt = 0; v.exp_ovf = 1'b1;
        v.exp_vld = 1'b0; v.exp_rd = 8'h0F;
        tbl.push_back(v);
        v.op = OP_CLR; v.exp_ovf = 1'b0;
        tbl.push_back(v);

        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_PUSH: do_push(tbl[i].dat, 5);
                OP_POP:  do_pop();
                default: begin
                    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
                    m_ovf = 1'b0;
                end
            endcase
            chk($sformatf("tbl%0d_cnt", i),   count,    tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_full", i),  full,     tbl[i].exp_cnt == DEPTH);
            chk($sformatf("tbl%0d_empty", i), empty,    tbl[i].exp_cnt == 0);
            chk($sformatf("tbl%0d_ovf", i),   overflow, tbl[i].exp_ovf);
            chk($sformatf("tbl%0d_vld", i),   rd_valid, tbl[i].exp_vld);
            chk($sformatf("tbl%0d_rd", i),    rd_data,  tbl[i].exp_rd);
        end

        // Simultaneous push and pop while full. With the strobe raised just
        // after a clock edge, the synchronised edge occupies the third cycle.
        for (int i = 0; i < DEPTH; i++) do_push(8'h20 + 8'(i), 4);
        state_chk("fullpp_pre");
        rx_byte = 8'h55;
        rx_ctrl = 1'b1;
        tick(); tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fullpp_vld", rd_valid, 1);
        chk("fullpp_rd",  rd_data,  8'h20);
        m_last = mq.pop_front();
        mq.push_back(8'h55);
        repeat (4) tick();
        rx_ctrl = 1'b0;
        repeat (4) tick();
        chk("fullpp_cnt", count,    16);
        chk("fullpp_ovf", overflow, 0);
        while (mq.size() > 1) pop_chk("fullpp_drain");
        pop_chk("fullpp_last");
        chk("fullpp_last_is_new", rd_data, 8'h55);
        state_chk("fullpp_post");

        // Clear coinciding with a dropped push: the set wins
        for (int i = 0; i < DEPTH; i++) do_push(8'h40 + 8'(i), 4);
        chk("ovfprio_pre", overflow, 0);
        rx_byte = 8'hEE;
        rx_ctrl = 1'b1;
        tick(); tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovfprio_set_wins", overflow, 1);
        m_ovf = 1'b1;
        repeat (4) tick();
        rx_ctrl = 1'b0;
        repeat (4) tick();
        state_chk("ovfprio_hold");
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        m_ovf = 1'b0;
        chk("ovfprio_clr", overflow, 0);
        while (mq.size() > 0) pop_chk("ovfprio_drain");
        pop_chk("pop_empty");
        state_chk("pop_empty_state");

        // Reset with entries stored and a strobe in flight
        for (int i = 0; i < 5; i++) do_push(8'h60 + 8'(i), 4);
        chk("rstmid_pre", count, 5);
        rx_byte = 8'h77;
        rx_ctrl = 1'b1;
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        repeat (4) tick();
        rx_ctrl = 1'b0;
        repeat (4) tick();
        state_chk("rstmid");
        chk("rstmid_vld", rd_valid, 0);
        chk("rstmid_rd",  rd_data,  8'h00);
        do_push(8'h3C, 6);
        state_chk("rstmid_fresh");
        pop_chk("rstmid_fresh_pop");

        // Random interleaved push/pop around the pointer wrap
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(1, 2);
            for (int j = 0; j < n; j++) begin
                do_push(8'($urandom), $urandom_range(3, 9));
                chk("rand_cnt_le2", (count <= 2), 1);
            end
            state_chk("rand_after_push");
            for (int j = 0; j < n; j++) pop_chk("rand_pop");
        end
        state_chk("rand_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
